// File: rtl/rf_wr_pkg.sv
// rtl/rf_wr_pkg.sv - shared parameters, FSM states and request type for the rf16x160 write controller
package rf_wr_pkg;

  localparam int DEPTH  = 16;
  localparam int WIDTH  = 160;
  localparam int NQUAD  = 4;
  localparam int QW     = WIDTH / NQUAD;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int FIFO_D = 2;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    COMMIT,
    RESP
  } wr_st_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [NQUAD-1:0]  qmask;
    logic [WIDTH-1:0]  data;
  } wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// rtl/rf_wr_fifo.sv - small in-order request buffer of wr_req_t entries
module rf_wr_fifo
  import rf_wr_pkg::*;
#(
  parameter int D = FIFO_D
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wr_req_t push_data,
  input  logic    pop,
  output wr_req_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  wr_req_t       mem_q [D];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage carries no reset; occupancy is tracked by the counter alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (cnt_q == CW'(D));
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/bw_r_rf16x160_wr_ctl.sv
// rtl/bw_r_rf16x160_wr_ctl.sv - write-side controller with per-entry sticky locks for the 16x160 register file
module bw_r_rf16x160_wr_ctl
  import rf_wr_pkg::*;
(
  input  logic              wr_clk,
  input  logic              reset,
  input  logic              wr_req_vld,
  output logic              wr_req_rdy,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [NQUAD-1:0]  wr_req_qmask,
  input  logic [WIDTH-1:0]  wr_req_data,
  input  logic              lk_set_vld,
  input  logic [DEPTH-1:0]  lk_set_mask,
  output logic [DEPTH-1:0]  lk_q,
  output logic [NQUAD-1:0]  ary_wen,
  output logic [ADDR_W-1:0] ary_waddr,
  output logic [WIDTH-1:0]  ary_wdata,
  output logic              wr_rsp_vld,
  input  logic              wr_rsp_rdy,
  output logic              wr_rsp_err
);

  wr_st_e            st_q;
  wr_req_t           op_q;
  logic              err_q;
  logic [NQUAD-1:0]  ary_wen_q;
  logic [ADDR_W-1:0] ary_waddr_q;
  logic [WIDTH-1:0]  ary_wdata_q;
  logic              rsp_vld_q;
  logic              rsp_err_q;
  logic [DEPTH-1:0]  lk_d;

  logic    fifo_push;
  logic    fifo_pop;
  logic    fifo_full;
  logic    fifo_empty;
  wr_req_t fifo_in;
  wr_req_t fifo_head;

  assign wr_req_rdy = !fifo_full && !reset;
  assign fifo_push  = wr_req_vld && wr_req_rdy;
  assign fifo_pop   = (st_q == IDLE) && !fifo_empty;
  assign fifo_in    = '{addr: wr_req_addr, qmask: wr_req_qmask, data: wr_req_data};

  rf_wr_fifo #(.D(FIFO_D)) u_fifo (
    .clk       (wr_clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A lock arriving in the same cycle as CHECK must already count against the op.
  always_comb begin
    lk_d = lk_q | (lk_set_vld ? lk_set_mask : '0);
  end

  // Single-op pipeline: pop, lock check, strobe, then hold the response until accepted.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      st_q        <= IDLE;
      op_q        <= '0;
      err_q       <= 1'b0;
      lk_q        <= '0;
      ary_wen_q   <= '0;
      ary_waddr_q <= '0;
      ary_wdata_q <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      lk_q <= lk_d;
      case (st_q)
        IDLE: begin
          if (!fifo_empty) begin
            op_q <= fifo_head;
            st_q <= CHECK;
          end
        end
        CHECK: begin
          err_q       <= lk_d[op_q.addr];
          ary_wen_q   <= lk_d[op_q.addr] ? '0 : op_q.qmask;
          ary_waddr_q <= op_q.addr;
          ary_wdata_q <= op_q.data;
          st_q        <= COMMIT;
        end
        COMMIT: begin
          ary_wen_q <= '0;
          rsp_vld_q <= 1'b1;
          rsp_err_q <= err_q;
          st_q      <= RESP;
        end
        RESP: begin
          if (wr_rsp_rdy) begin
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            st_q      <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign ary_wen    = ary_wen_q;
  assign ary_waddr  = ary_waddr_q;
  assign ary_wdata  = ary_wdata_q;
  assign wr_rsp_vld = rsp_vld_q;
  assign wr_rsp_err = rsp_err_q;

endmodule

// File: tb/tb_bw_r_rf16x160_wr_ctl.sv
// tb/tb_bw_r_rf16x160_wr_ctl.sv - randomized self-checking bench against a timeline reference model
module tb_bw_r_rf16x160_wr_ctl;

  logic         wr_clk = 1'b0;
  logic         reset;
  logic         wr_req_vld;
  logic         wr_req_rdy;
  logic [3:0]   wr_req_addr;
  logic [3:0]   wr_req_qmask;
  logic [159:0] wr_req_data;
  logic         lk_set_vld;
  logic [15:0]  lk_set_mask;
  logic [15:0]  lk_q;
  logic [3:0]   ary_wen;
  logic [3:0]   ary_waddr;
  logic [159:0] ary_wdata;
  logic         wr_rsp_vld;
  logic         wr_rsp_rdy;
  logic         wr_rsp_err;

  always #5 wr_clk = ~wr_clk;

  bw_r_rf16x160_wr_ctl dut (
    .wr_clk       (wr_clk),
    .reset        (reset),
    .wr_req_vld   (wr_req_vld),
    .wr_req_rdy   (wr_req_rdy),
    .wr_req_addr  (wr_req_addr),
    .wr_req_qmask (wr_req_qmask),
    .wr_req_data  (wr_req_data),
    .lk_set_vld   (lk_set_vld),
    .lk_set_mask  (lk_set_mask),
    .lk_q         (lk_q),
    .ary_wen      (ary_wen),
    .ary_waddr    (ary_waddr),
    .ary_wdata    (ary_wdata),
    .wr_rsp_vld   (wr_rsp_vld),
    .wr_rsp_rdy   (wr_rsp_rdy),
    .wr_rsp_err   (wr_rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each request is placed on a cycle timeline. It is popped the first
  // cycle the buffer holds it and the previous response has been accepted; lock check is
  // one cycle later, strobe two, response from three until accepted.
  typedef struct {
    logic [3:0]   addr;
    logic [3:0]   qm;
    logic [159:0] data;
    int           acc;
  } mreq_t;

  mreq_t       pend[$];
  mreq_t       cur;
  bit          active  = 0;
  int          pcyc    = 0;
  bit          merr    = 0;
  int          last_hs = -10;
  logic [15:0] lk_cum  = '0;
  int          cyc     = 0;
  bit          mon_en  = 0;

  always @(posedge wr_clk) cyc <= cyc + 1;

  always @(negedge wr_clk) begin
    logic       exp_rdy;
    logic [3:0] exp_wen;
    logic       exp_vld;
    if (mon_en) begin
      exp_rdy = !reset && (pend.size() < 2);
      chk("rdy", 160'(wr_req_rdy), 160'(exp_rdy));
      chk("lk_q", 160'(lk_q), 160'(lk_cum));
      if (lk_set_vld && !reset) lk_cum = lk_cum | lk_set_mask;
      if (!active && pend.size() > 0 && pend[0].acc < cyc && last_hs < cyc) begin
        cur    = pend.pop_front();
        active = 1;
        pcyc   = cyc;
      end
      if (active && cyc == pcyc + 1) merr = lk_cum[cur.addr];
      exp_wen = (active && cyc == pcyc + 2 && !merr) ? cur.qm : 4'h0;
      chk("ary_wen", 160'(ary_wen), 160'(exp_wen));
      if (exp_wen != 4'h0) begin
        chk("ary_waddr", 160'(ary_waddr), 160'(cur.addr));
        chk("ary_wdata", ary_wdata, cur.data);
      end
      exp_vld = active && cyc >= pcyc + 3;
      chk("rsp_vld", 160'(wr_rsp_vld), 160'(exp_vld));
      if (exp_vld) begin
        chk("rsp_err", 160'(wr_rsp_err), 160'(merr));
        if (wr_rsp_rdy) begin
          active  = 0;
          last_hs = cyc;
        end
      end
      if (wr_req_vld && exp_rdy) pend.push_back('{wr_req_addr, wr_req_qmask, wr_req_data, cyc});
      if (reset) begin
        pend.delete();
        active  = 0;
        lk_cum  = '0;
        last_hs = -10;
      end
    end
  end

  function automatic logic [159:0] rnd160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] qm, input logic [159:0] d);
    bit got = 0;
    wr_req_vld   = 1'b1;
    wr_req_addr  = a;
    wr_req_qmask = qm;
    wr_req_data  = d;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge wr_clk);
      got = wr_req_rdy;
      @(posedge wr_clk);
      #1;
    end
    wr_req_vld = 1'b0;
    if (!got) chk("send_timeout", 160'(0), 160'(1));
  endtask

  task automatic lock_pulse(input logic [15:0] m);
    lk_set_vld  = 1'b1;
    lk_set_mask = m;
    step(1);
    lk_set_vld  = 1'b0;
    lk_set_mask = '0;
  endtask

  initial begin
    reset        = 1'b1;
    wr_req_vld   = 1'b0;
    wr_req_addr  = '0;
    wr_req_qmask = '0;
    wr_req_data  = '0;
    lk_set_vld   = 1'b0;
    lk_set_mask  = '0;
    wr_rsp_rdy   = 1'b0;
    step(2);
    mon_en = 1;
    chk("rst_rdy", 160'(wr_req_rdy), 160'(0));
    chk("rst_wen", 160'(ary_wen), 160'(0));
    chk("rst_waddr", 160'(ary_waddr), 160'(0));
    chk("rst_wdata", ary_wdata, 160'(0));
    chk("rst_rsp_vld", 160'(wr_rsp_vld), 160'(0));
    chk("rst_rsp_err", 160'(wr_rsp_err), 160'(0));
    chk("rst_lk", 160'(lk_q), 160'(0));
    reset = 1'b0;
    @(negedge wr_clk);
    chk("rdy_after_rst", 160'(wr_req_rdy), 160'(1));
    @(posedge wr_clk);
    #1;
    wr_rsp_rdy = 1'b1;

    send(4'd3, 4'hF, {5{32'hA5A5_A5A5}});
    step(7);
    send(4'd7, 4'b0101, rnd160());
    step(7);

    lock_pulse(16'h0020);
    send(4'd5, 4'hF, rnd160());
    step(7);
    chk("lk_0020", 160'(lk_q), 160'(16'h0020));

    send(4'd9, 4'hF, rnd160());
    step(1);
    lock_pulse(16'h0200);
    chk("same_cyc_lock_wen", 160'(ary_wen), 160'(0));
    step(6);

    send(4'd10, 4'b0011, rnd160());
    step(2);
    chk("commit_lock_wen", 160'(ary_wen), 160'(4'b0011));
    lock_pulse(16'h0400);
    step(6);
    chk("lk_accum", 160'(lk_q), 160'(16'h0620));

    send(4'd12, 4'h0, rnd160());
    step(7);

    wr_rsp_rdy = 1'b0;
    send(4'd1, 4'hF, rnd160());
    send(4'd2, 4'h3, rnd160());
    send(4'd4, 4'hC, rnd160());
    chk("bp_rdy_low", 160'(wr_req_rdy), 160'(0));
    step(4);
    wr_rsp_rdy = 1'b1;
    step(20);

    send(4'd11, 4'hF, rnd160());
    step(2);
    chk("pre_rst_wen", 160'(ary_wen), 160'(4'hF));
    reset = 1'b1;
    step(1);
    chk("mid_rst_wen", 160'(ary_wen), 160'(0));
    chk("mid_rst_rsp", 160'(wr_rsp_vld), 160'(0));
    chk("mid_rst_lk", 160'(lk_q), 160'(0));
    reset = 1'b0;
    step(8);
    chk("post_rst_rdy", 160'(wr_req_rdy), 160'(1));

    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      wr_req_vld   = ($urandom_range(0, 9) < 6);
      wr_req_addr  = 4'($urandom_range(0, 15));
      wr_req_qmask = 4'($urandom_range(0, 15));
      wr_req_data  = rnd160();
      lk_set_vld   = ($urandom_range(0, 39) == 0);
      lk_set_mask  = 16'(1) << $urandom_range(0, 15);
      wr_rsp_rdy   = ($urandom_range(0, 9) < 7);
      step(1);
    end

    reset       = 1'b0;
    wr_req_vld  = 1'b0;
    lk_set_vld  = 1'b0;
    lk_set_mask = '0;
    wr_rsp_rdy  = 1'b1;
    step(40);
    chk("drain", 160'(pend.size() + int'(active)), 160'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
